// File: rtl/fe_lane_pkg.sv
// Shared types and constants for the front-end lane serializer: FSM state
// encoding, wide/narrow ratio helper and the PRBS-15 polynomial and seed.
package fe_lane_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } lane_state_e;

  // x^15 + x^14 + 1: feedback taps are state bits 14 and 13
  localparam logic [14:0] PRBS15_POLY = 15'h6000;
  localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

  function automatic int unsigned lane_ratio(input int unsigned out_w,
                                             input int unsigned in_w);
    return out_w / in_w;
  endfunction

  function automatic logic [14:0] prbs15_step(input logic [14:0] s);
    return {s[13:0], ^(s & PRBS15_POLY)};
  endfunction

endpackage

// File: rtl/fe_lane_ser_prbs15.sv
// PRBS-15 test-pattern source for fe_lane_ser; produces N_SAMPLES consecutive
// LFSR samples per lane word and advances by that many steps when adv is high.
module fe_lane_prbs15
  import fe_lane_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = 8,
  parameter int unsigned N_SAMPLES = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 adv,
  output logic [N_SAMPLES-1:0][ADC_WIDTH-1:0] samples
);

  logic [14:0] lfsr_q;
  logic [14:0] lfsr_d;

  // Sample j is the LFSR state after j steps; lfsr_d ends N_SAMPLES steps on
  always_comb begin
    lfsr_d  = lfsr_q;
    samples = '0;
    for (int unsigned j = 0; j < N_SAMPLES; j++) begin
      samples[j] = lfsr_d[ADC_WIDTH-1:0];
      lfsr_d     = prbs15_step(lfsr_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS15_SEED;
    end else if (adv) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/fe_lane_ser.sv
// Wide-to-narrow lane serializer with one-word skid buffer and bit-major
// output slices. Define FE_LANE_SER_PRBS_EN to add the prbs_mode test source.
module fe_lane_ser
  import fe_lane_pkg::*;
#(
  parameter int unsigned ADC_WIDTH     = 8,
  parameter int unsigned DES_IN_WIDTH  = 4,
  parameter int unsigned DES_OUT_WIDTH = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DES_OUT_WIDTH-1:0][ADC_WIDTH-1:0]  in_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [ADC_WIDTH-1:0][DES_IN_WIDTH-1:0]   out_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [15:0]                              underflow_cnt
`ifdef FE_LANE_SER_PRBS_EN
  ,
  input  logic                                     prbs_mode
`endif
);

  localparam int unsigned R    = lane_ratio(DES_OUT_WIDTH, DES_IN_WIDTH);
  localparam int unsigned CW   = $clog2(R);
  localparam logic [CW-1:0] LAST = CW'(R - 1);

  typedef logic [R-1:0][DES_IN_WIDTH-1:0][ADC_WIDTH-1:0] word_t;

  lane_state_e state_q, state_d;
  word_t       active_q, shadow_q;
  logic [CW-1:0] slice_q;
  logic        in_ready_q;
  logic        started_q;
  logic        ld_act_in, ld_act_sh, ld_sh;
  logic        acc, adv, ret, fsm_valid;
  logic        prbs_sel, prbs_on;
  logic [DES_IN_WIDTH-1:0][ADC_WIDTH-1:0] cur_samples;

`ifdef FE_LANE_SER_PRBS_EN
  logic alive_q;
  logic [DES_IN_WIDTH-1:0][ADC_WIDTH-1:0] prbs_samples;

  // alive_q keeps out_valid low through reset and the first edge after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  fe_lane_prbs15 #(
    .ADC_WIDTH (ADC_WIDTH),
    .N_SAMPLES (DES_IN_WIDTH)
  ) u_prbs (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (prbs_on && out_ready),
    .samples (prbs_samples)
  );

  assign prbs_sel    = prbs_mode;
  assign prbs_on     = prbs_mode && alive_q;
  assign in_ready    = in_ready_q && !prbs_mode;
  assign cur_samples = prbs_on ? prbs_samples : active_q[slice_q];
`else
  assign prbs_sel    = 1'b0;
  assign prbs_on     = 1'b0;
  assign in_ready    = in_ready_q;
  assign cur_samples = active_q[slice_q];
`endif

  assign fsm_valid = (state_q != IDLE);
  assign out_valid = fsm_valid || prbs_on;
  assign acc       = in_valid && in_ready;
  assign adv       = fsm_valid && out_ready && !prbs_sel;
  assign ret       = adv && (slice_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld_act_in = 1'b0;
    ld_act_sh = 1'b0;
    ld_sh     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          ld_act_in = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (ret && acc) begin
          ld_act_in = 1'b1;
        end else if (ret) begin
          state_d = IDLE;
        end else if (acc) begin
          ld_sh   = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        // Retire promotes the shadow; a same-cycle accept refills it
        if (ret) begin
          ld_act_sh = 1'b1;
          if (acc) ld_sh = 1'b1;
          else     state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= '0;
      shadow_q      <= '0;
      slice_q       <= '0;
      in_ready_q    <= 1'b0;
      started_q     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      in_ready_q <= (state_d != FULL);
      if (ld_act_in)      active_q <= word_t'(in_data);
      else if (ld_act_sh) active_q <= shadow_q;
      if (ld_sh)          shadow_q <= word_t'(in_data);
      if (adv)            slice_q  <= (slice_q == LAST) ? '0 : slice_q + 1'b1;
      if (acc)            started_q <= 1'b1;
      if (started_q && out_ready && !out_valid && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  // Transpose the current slice from sample-major to bit-major
  always_comb begin
    out_data = '0;
    for (int unsigned j = 0; j < DES_IN_WIDTH; j++) begin
      for (int unsigned b = 0; b < ADC_WIDTH; b++) begin
        out_data[b][j] = cur_samples[j][b];
      end
    end
  end

endmodule
